// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, MMIO offsets and FSM state type for dmem_unit
package dmem_pkg;

    // Load/store size field, funct3 encoding from the core's memory stage.
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Byte offsets inside the 8-byte MMIO window.
    localparam logic [2:0] MMIO_CYCLE  = 3'd0;
    localparam logic [2:0] MMIO_TOHOST = 3'd4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_lane_ext.sv
// rtl/dmem_lane_ext.sv - byte-enable, store-data replication and load extraction/extension
//
// Ports:
//   size_i     funct3 size code
//   lane_i     byte lane, address bits [1:0]
//   word_i     32-bit word fetched from the array or MMIO
//   wdata_i    raw store data from the core
//   be_o       byte enables for a store (zero for non-storing sizes)
//   wdata_o    store data replicated onto every lane it may land in
//   rdata_o    lane-aligned, sign/zero-extended load data
//   misalign_o store would straddle its natural alignment
module dmem_lane_ext
    import dmem_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel   = word_i[{lane_i, 3'b000} +: 8];
    assign half_sel   = lane_i[1] ? word_i[31:16] : word_i[15:0];
    assign misalign_o = ((size_i == SZ_H) && lane_i[0]) ||
                        ((size_i == SZ_W) && (lane_i != 2'b00));

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = '0;
        rdata_o = '0;
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{half_sel[15]}}, half_sel};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = word_i;
            end
            SZ_BU:   rdata_o = {24'b0, byte_sel};
            SZ_HU:   rdata_o = {16'b0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - byte-addressable data memory with clear sequencer and MMIO cycle/tohost window
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   dmemAddr     byte address;  dmemWdata store data;  dmemSize funct3 size;  dmemWen store strobe
//   dmemRdata    combinational extended load data (0 while clearing)
//   memReady     array cleared, traffic accepted
//   misalignErr  sticky flag: a misaligned store was dropped
//   tohostValid  sticky flag: tohost written;  tohostData last tohost value
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmemAddr,
    input  logic [31:0] dmemWdata,
    input  logic [2:0]  dmemSize,
    input  logic        dmemWen,
    output logic [31:0] dmemRdata,
    output logic        memReady,
    output logic        misalignErr,
    output logic        tohostValid,
    output logic [31:0] tohostData
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e         state_q, state_d;
    logic [AW-1:0]  clr_idx_q, clr_idx_d;
    logic [31:0]    mem_q [DEPTH_WORDS];
    logic [31:0]    cycle_q;
    logic [31:0]    tohost_q;
    logic           tohost_vld_q;
    logic           misalign_q;

    logic           arr_hit;
    logic           mmio_hit;
    logic [AW-1:0]  widx;
    logic [31:0]    rword;
    logic [3:0]     be;
    logic [31:0]    wdata_al;
    logic [31:0]    ext_rdata;
    logic           misalign;
    logic           store_go;
    logic           arr_wr;
    logic           tohost_wr;

    assign arr_hit  = dmemAddr < 32'(DEPTH_WORDS * 4);
    assign mmio_hit = dmemAddr[31:3] == MMIO_BASE[31:3];
    assign widx     = dmemAddr[AW+1:2];

    always_comb begin
        rword = '0;
        if (arr_hit) begin
            rword = mem_q[widx];
        end else if (mmio_hit) begin
            rword = ({dmemAddr[2], 2'b00} == MMIO_CYCLE) ? cycle_q : tohost_q;
        end
    end

    // One extractor serves both directions: the load result comes from the
    // addressed word, the byte enables and replicated data feed the store.
    dmem_lane_ext u_lane_ext (
        .size_i     (dmemSize),
        .lane_i     (dmemAddr[1:0]),
        .word_i     (rword),
        .wdata_i    (dmemWdata),
        .be_o       (be),
        .wdata_o    (wdata_al),
        .rdata_o    (ext_rdata),
        .misalign_o (misalign)
    );

    assign dmemRdata = (state_q == RUN) ? ext_rdata : '0;

    // Stores only count in RUN; a reset cycle must not commit core traffic.
    assign store_go  = !rst && (state_q == RUN) && dmemWen;
    assign arr_wr    = store_go && !misalign && arr_hit;
    assign tohost_wr = store_go && !misalign && mmio_hit &&
                       (dmemAddr[2:0] == MMIO_TOHOST) && (dmemSize == SZ_W);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN:     ;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            cycle_q      <= '0;
            tohost_q     <= '0;
            tohost_vld_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            cycle_q   <= (state_q == RUN) ? cycle_q + 32'd1 : '0;
            if (store_go && misalign) begin
                misalign_q <= 1'b1;
            end
            if (tohost_wr) begin
                tohost_q     <= dmemWdata;
                tohost_vld_q <= 1'b1;
            end
        end
    end

    // Array storage has no reset; the CLEAR sweep provides the known-zero state.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else if (arr_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[widx][8*i +: 8] <= wdata_al[8*i +: 8];
                end
            end
        end
    end

    assign memReady    = (state_q == RUN);
    assign misalignErr = misalign_q;
    assign tohostValid = tohost_vld_q;
    assign tohostData  = tohost_q;

endmodule
